// File: rtl/riscv_defs.sv
// Shared CPU-side definitions: data-memory size codes, MMIO register offsets,
// responder state encoding, request record and lane helper functions.
package riscv_defs;

  localparam logic [1:0] DMEM_SIZE_B = 2'b00;
  localparam logic [1:0] DMEM_SIZE_H = 2'b01;
  localparam logic [1:0] DMEM_SIZE_W = 2'b10;

  localparam logic [9:0] DMEM_MMIO_LED  = 10'h000;
  localparam logic [9:0] DMEM_MMIO_SW   = 10'h004;
  localparam logic [9:0] DMEM_MMIO_PERF = 10'h008;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == DMEM_SIZE_H && a[0]) || (size == DMEM_SIZE_W && a != 2'b00);
  endfunction

  function automatic logic [3:0] dmem_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      DMEM_SIZE_B: dmem_be = 4'b0001 << a;
      DMEM_SIZE_H: dmem_be = a[1] ? 4'b1100 : 4'b0011;
      default:     dmem_be = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and clear everything above it.
  function automatic logic [31:0] dmem_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] a);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (size)
      DMEM_SIZE_B: dmem_extract = {24'b0, s[7:0]};
      DMEM_SIZE_H: dmem_extract = {16'b0, s[15:0]};
      default:     dmem_extract = s;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module riscv_dmem_ram
  #(parameter int ADDR_WIDTH = 14,
    parameter int NUM_LANES  = 4)
  (input  logic                          clk,
   input  logic                          en,
   input  logic                          we,
   input  logic [NUM_LANES-1:0]          be,
   input  logic [ADDR_WIDTH-1:0]         addr,
   input  logic [NUM_LANES-1:0][7:0]     wdata,
   output logic [NUM_LANES-1:0][7:0]     rdata);

  logic [NUM_LANES-1:0][7:0] mem [2**ADDR_WIDTH];

  // rdata holds its last value unless a read is issued.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NUM_LANES; i++)
          if (be[i]) mem[addr][i] <= wdata[i];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-side memory responder: RAM plus LED/switch MMIO window with wait states.
// Define DMEM_PERF_CNT_EN to map an accepted-request counter at MMIO offset 0x008.
module riscv_dmem_responder
  import riscv_defs::*;
  #(parameter int          ADDR_WIDTH  = 14,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FC00)
  (input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] led_out,
   input  logic [15:0] sw_in);

  dmem_state_e state, next;
  dmem_req_t   req_q, cur;
  logic [3:0]  cnt;
  logic [15:0] sw_meta, sw_sync;
  logic [31:0] mmio_q, mmio_rd, off, wlanes, ram_rdata, rd_word;
  logic [3:0]  be;
  logic        accept, is_mmio, in_win, hit_led, hit_sw, hit_perf, err;
  logic        commit, commit_ok, ram_we, ram_en, led_we;
  logic [1:0]  unused_off;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  assign req_ready = (state == DMEM_ST_IDLE);
  assign accept    = req_ready && req_valid;

  // In IDLE the live inputs are decoded so a zero-wait store can commit on
  // the accept edge; afterwards the latched copy is authoritative.
  always_comb begin
    cur = req_q;
    if (state == DMEM_ST_IDLE) begin
      cur.we    = req_we;
      cur.size  = req_size;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  assign is_mmio    = (cur.addr >= MMIO_BASE);
  assign off        = cur.addr - MMIO_BASE;
  assign unused_off = off[1:0];
  assign in_win     = is_mmio && (off[31:10] == '0);
  assign hit_led    = in_win && (off[9:2] == DMEM_MMIO_LED[9:2]);
  assign hit_sw     = in_win && (off[9:2] == DMEM_MMIO_SW[9:2]);
`ifdef DMEM_PERF_CNT_EN
  assign hit_perf   = in_win && (off[9:2] == DMEM_MMIO_PERF[9:2]);
`else
  assign hit_perf   = 1'b0;
`endif

  assign err = (cur.size == 2'b11) || dmem_misaligned(cur.size, cur.addr[1:0]) ||
               (is_mmio && !(hit_led || hit_sw || hit_perf));

  assign be = dmem_be(cur.size, cur.addr[1:0]);
  always_comb begin
    case (cur.size)
      DMEM_SIZE_B: wlanes = {4{cur.wdata[7:0]}};
      DMEM_SIZE_H: wlanes = {2{cur.wdata[15:0]}};
      default:     wlanes = cur.wdata;
    endcase
  end

  always_comb begin
    mmio_rd = '0;
    if (hit_led)      mmio_rd = {16'b0, led_out};
    else if (hit_sw)  mmio_rd = {16'b0, sw_sync};
`ifdef DMEM_PERF_CNT_EN
    else if (hit_perf) mmio_rd = perf_cnt;
`endif
  end

  always_comb begin
    next = state;
    case (state)
      DMEM_ST_IDLE: if (req_valid) next = (WAIT_CYCLES > 0) ? DMEM_ST_WAIT : DMEM_ST_RESP;
      DMEM_ST_WAIT: if (cnt == 4'd1) next = DMEM_ST_RESP;
      DMEM_ST_RESP: next = DMEM_ST_IDLE;
      default:      next = DMEM_ST_IDLE;
    endcase
  end

  // Side effects land on the edge that enters RESP, so a reset before it aborts cleanly.
  assign commit    = (next == DMEM_ST_RESP) && !rst;
  assign commit_ok = commit && cur.we && !err;
  assign ram_we    = commit_ok && !is_mmio;
  assign led_we    = commit_ok && hit_led;
  assign ram_en    = (accept && !rst) || ram_we;

  riscv_dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (be),
    .addr  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata (wlanes),
    .rdata (ram_rdata));

  assign rd_word = is_mmio ? mmio_q : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= DMEM_ST_IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      req_q     <= '0;
      mmio_q    <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      led_out   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
      perf_cnt  <= '0;
`endif
    end else begin
      sw_meta   <= sw_in;
      sw_sync   <= sw_meta;
      rsp_valid <= (state == DMEM_ST_RESP);
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (state == DMEM_ST_RESP) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur.we) ? '0 : dmem_extract(rd_word, cur.size, cur.addr[1:0]);
      end
      if (accept) begin
        req_q  <= cur;
        cnt    <= 4'(WAIT_CYCLES);
        mmio_q <= mmio_rd;
      end else if (state == DMEM_ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (led_we) begin
        if (be[0]) led_out[7:0]  <= wlanes[7:0];
        if (be[1]) led_out[15:8] <= wlanes[15:8];
      end
`ifdef DMEM_PERF_CNT_EN
      if (accept) perf_cnt <= perf_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench: one responder with one wait state, one with three.
module tb_riscv_dmem_responder;
  import riscv_defs::*;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst1, rst3, valid1, valid3;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] sw_in;
  logic        req_ready1, req_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3;
  logic [31:0] rsp_rdata1, rsp_rdata3;
  logic [15:0] led1, led3;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_dmem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .led_out(led1), .sw_in(sw_in));

  riscv_dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(req_ready3), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .led_out(led3), .sw_in(sw_in));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t x;
    if (rsp_valid1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", q1.size(), 1);
      else begin
        x = q1.pop_front();
        chk("rsp1_rdata", rsp_rdata1, x.d);
        chk("rsp1_err", {31'b0, rsp_err1}, {31'b0, x.e});
        chk("rsp1_latency", 32'(cyc - x.c), 2);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t x;
    if (rsp_valid3) begin
      if (q3.size() == 0) chk("rsp3_unexpected", q3.size(), 1);
      else begin
        x = q3.pop_front();
        chk("rsp3_rdata", rsp_rdata3, x.d);
        chk("rsp3_err", {31'b0, rsp_err3}, {31'b0, x.e});
        chk("rsp3_latency", 32'(cyc - x.c), 4);
      end
    end
  end

  task automatic issue(input bit d3, input bit we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input bit ee);
    exp_t x;
    @(negedge clk);
    chk(d3 ? "ready3" : "ready1", {31'b0, d3 ? req_ready3 : req_ready1}, 1);
    req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    if (d3) valid3 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0; valid3 = 1'b0;
    x.d = ed; x.e = ee; x.c = cyc;
    if (d3) q3.push_back(x); else q1.push_back(x);
  endtask

  task automatic wait_rsp(input bit d3);
    for (int i = 0; i < 30; i++) begin
      if ((d3 ? q3.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if ((d3 ? q3.size() : q1.size()) != 0) begin
      chk("rsp_timeout", d3 ? q3.size() : q1.size(), 0);
      if (d3) q3.delete(); else q1.delete();
    end
  endtask

  task automatic rq(input bit d3, input bit we, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] ed, input bit ee);
    issue(d3, we, sz, a, wd, ed, ee);
    wait_rsp(d3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready1", {31'b0, req_ready1}, 1);
    chk("rst_valid1", {31'b0, rsp_valid1}, 0);
    chk("rst_rdata1", rsp_rdata1, 0);
    chk("rst_err1", {31'b0, rsp_err1}, 0);
    chk("rst_led1", {16'b0, led1}, 0);
    chk("rst_ready3", {31'b0, req_ready3}, 1);
    chk("rst_valid3", {31'b0, rsp_valid3}, 0);
    rst1 = 1'b0; rst3 = 1'b0;

    // RAM word, byte and half accesses
    rq(0, 1, DMEM_SIZE_W, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    rq(0, 0, DMEM_SIZE_W, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    rq(0, 1, DMEM_SIZE_B, 32'h1, 32'hFFFFFF55, 32'h0, 0);
    rq(0, 0, DMEM_SIZE_W, 32'h0, 32'h0, 32'hDEAD55EF, 0);
    rq(0, 0, DMEM_SIZE_B, 32'h3, 32'h0, 32'h000000DE, 0);
    rq(0, 0, DMEM_SIZE_H, 32'h2, 32'h0, 32'h0000DEAD, 0);
    rq(0, 0, DMEM_SIZE_W, 32'h10000, 32'h0, 32'hDEAD55EF, 0);
    rq(0, 1, DMEM_SIZE_W, 32'hC, 32'h0, 32'h0, 0);
    rq(0, 1, DMEM_SIZE_H, 32'hE, 32'hFFFF7777, 32'h0, 0);
    rq(0, 0, DMEM_SIZE_W, 32'hC, 32'h0, 32'h77770000, 0);

    // Errors: misaligned and illegal size, no write on error
    rq(0, 0, DMEM_SIZE_H, 32'h1, 32'h0, 32'h0, 1);
    rq(0, 0, DMEM_SIZE_W, 32'h2, 32'h0, 32'h0, 1);
    rq(0, 0, 2'b11, 32'h0, 32'h0, 32'h0, 1);
    rq(0, 1, DMEM_SIZE_W, 32'h4, 32'h12345678, 32'h0, 0);
    rq(0, 1, DMEM_SIZE_W, 32'h6, 32'hCAFECAFE, 32'h0, 1);
    rq(0, 0, DMEM_SIZE_W, 32'h4, 32'h0, 32'h12345678, 0);

    // LED register commits on the edge that enters RESP
    issue(0, 1, DMEM_SIZE_H, BASE, 32'h0000A5A5, 32'h0, 0);
    @(negedge clk);
    chk("led_not_early", {16'b0, led1}, 0);
    @(negedge clk);
    chk("led_commit", {16'b0, led1}, 32'h0000A5A5);
    wait_rsp(0);
    rq(0, 1, DMEM_SIZE_B, BASE + 2, 32'h000000FF, 32'h0, 0);
    chk("led_lane2_ignored", {16'b0, led1}, 32'h0000A5A5);
    rq(0, 1, DMEM_SIZE_B, BASE + 1, 32'h0000003C, 32'h0, 0);
    chk("led_byte1", {16'b0, led1}, 32'h00003CA5);
    rq(0, 0, DMEM_SIZE_W, BASE, 32'h0, 32'h00003CA5, 0);
    rq(0, 0, DMEM_SIZE_B, BASE + 1, 32'h0, 32'h0000003C, 0);

    // Switches through the synchronizer, read-only, unmapped offsets
    sw_in = 16'h00F0;
    repeat (3) @(negedge clk);
    rq(0, 0, DMEM_SIZE_W, BASE + 4, 32'h0, 32'h000000F0, 0);
    rq(0, 1, DMEM_SIZE_W, BASE + 4, 32'hFFFFFFFF, 32'h0, 0);
    rq(0, 0, DMEM_SIZE_H, BASE + 4, 32'h0, 32'h000000F0, 0);
    rq(0, 0, DMEM_SIZE_W, BASE + 32'h10, 32'h0, 32'h0, 1);
    rq(0, 1, DMEM_SIZE_W, BASE + 32'h3FC, 32'h1, 32'h0, 1);

    // Three wait states; reset during WAIT aborts a store
    rq(1, 1, DMEM_SIZE_W, 32'h8, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    req_we = 1'b1; req_size = DMEM_SIZE_W; req_addr = 32'h8; req_wdata = 32'h1;
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("abort_ready", {31'b0, req_ready3}, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, rsp_valid3}, 0);
    end

    // Five accepts after reset, then the performance counter
    rq(1, 0, DMEM_SIZE_W, 32'h8, 32'h0, 32'hCAFEF00D, 0);
    rq(1, 1, DMEM_SIZE_W, 32'h10, 32'h11223344, 32'h0, 0);
    rq(1, 0, DMEM_SIZE_W, 32'h10, 32'h0, 32'h11223344, 0);
    rq(1, 1, DMEM_SIZE_B, 32'h11, 32'h000000AA, 32'h0, 0);
    rq(1, 0, DMEM_SIZE_H, 32'h10, 32'h0, 32'h0000AA44, 0);
`ifdef DMEM_PERF_CNT_EN
    rq(1, 0, DMEM_SIZE_W, BASE + 8, 32'h0, 32'd5, 0);
    rq(1, 1, DMEM_SIZE_W, BASE + 8, 32'h0, 32'h0, 0);
    rq(1, 0, DMEM_SIZE_W, BASE + 8, 32'h0, 32'd7, 0);
`else
    rq(1, 0, DMEM_SIZE_W, BASE + 8, 32'h0, 32'h0, 1);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
- Data-side memory responder: the far end of the CPU's load/store interface.
- Accepts one request at a time over a valid/ready handshake and performs byte, half or word reads and writes to on-chip RAM, or to a small MMIO register window (LEDs, switches).
- Returns lane-aligned read data after a programmable wait-state count. The CPU core does sign/zero extension.

Parameters:
- ADDR_WIDTH, 14, word-address bits of the RAM (2^14 words = 64 KiB).
- WAIT_CYCLES, 1, extra wait states between accept and response (0..15).
- MMIO_BASE, 32'hFFFF_FC00, first byte address of the 1 KiB MMIO window.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned (sb uses [7:0], sh uses [15:0]).
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data shifted to [n-1:0], upper bits zero; 0 for stores and errors.
- rsp_err  output  1  misaligned access, illegal size, or unmapped MMIO offset.
- led_out  output  16  LED register.
- sw_in  input  16  asynchronous switch inputs.

Behaviour:
- Reset values:
  - state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; led_out 0.
  - wait counter 0; switch synchronizer 0.
  - RAM contents are not reset.
- IDLE:
  - On req_valid && req_ready, latch we/size/addr/wdata and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else go to RESP.
- WAIT:
  - Decrement the counter each cycle; req_ready = 0.
  - When the counter reaches 1, go to RESP next.
- RESP:
  - rsp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next state is IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge. Minimum request spacing is WAIT_CYCLES+2 cycles.
- Store commit: the write happens on the clock edge that enters RESP, never earlier. Reset asserted before that edge aborts the access with no write.
- Reset mid-WAIT or mid-RESP: go to IDLE next cycle and drop rsp_valid. No response is ever produced for the aborted request.
- Alignment: error if half and addr[0] = 1, or word and addr[1:0] != 0, or size = 11. An error response has rsp_err = 1, rdata 0, and no write.
- RAM region (addr < MMIO_BASE):
  - Word index is addr[ADDR_WIDTH+1:2]; higher bits are ignored (aliasing).
  - Byte lane for sb: addr[1:0]. Half lane for sh: addr[1].
  - Writes use byte enables; other lanes are preserved.
  - Read is synchronous: the RAM is read on accept and the word is held; lane extraction happens on the held word.
- MMIO region (addr >= MMIO_BASE), offset = addr - MMIO_BASE:
  - 0x000: LED register. Writes follow byte/half rules on [15:0]; byte lanes 2..3 are ignored. Reads return {16'b0, led_out}.
  - 0x004: switches, through a 2-flop synchronizer. Read-only; writes are silently ignored with rsp_err = 0.
  - Any other offset: rsp_err = 1.
- Inputs are sampled only on accept. req_* changes while req_ready = 0 have no effect.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - MMIO offset 0x008 is a read-only 32-bit count of accepted requests (all kinds, including errors).
  - The count increments on the accept edge, wraps from 32'hFFFF_FFFF to 0, and resets to 0.
  - Writes to 0x008 are ignored with no error.
- Undefined: offset 0x008 is unmapped and returns rsp_err = 1.

Decomposition:
- Shared package riscv_defs, alongside the existing CPU defines:
  - DMEM_SIZE_B/H/W codes.
  - MMIO offsets DMEM_MMIO_LED, DMEM_MMIO_SW, DMEM_MMIO_PERF.
  - State encodings DMEM_ST_IDLE, DMEM_ST_WAIT, DMEM_ST_RESP.
- Sub-module riscv_dmem_ram: single-port, 2^ADDR_WIDTH x 32 RAM with 4-bit byte-enable write and registered read. FSM, decode, lane logic and MMIO stay in the top.

Test Plan:
1. WAIT_CYCLES = 1. sw 0x000 = 32'hDEADBEEF, then lw 0x000 -> rsp_valid 2 cycles after each accept; rdata 32'hDEADBEEF; err 0.
2. sb 0x001 = 8'h55 over 32'hDEADBEEF, then lw 0x000 -> 32'hDEAD55EF. lb 0x003 -> 32'h000000DE. lh 0x002 -> 32'h0000DEAD.
3. lh 0x001 and lw 0x002 -> rsp_err 1, rdata 0. A prior sw 0x004 = 32'h12345678 followed by misaligned sw 0x006 -> lw 0x004 still returns 32'h12345678.
4. sh MMIO_BASE+0 = 16'hA5A5 -> led_out 16'hA5A5 on the RESP edge. sw_in = 16'h00F0, then lw MMIO_BASE+4 (issued >= 3 cycles later) -> 32'h000000F0. lw MMIO_BASE+0x10 -> err 1.
5. WAIT_CYCLES = 3. Accept sw 0x008 = 1, assert rst during WAIT -> no rsp_valid, req_ready 1 after reset. lw 0x008 returns the old contents, not 1.
6. With DMEM_PERF_CNT_EN: 5 accepted requests, then lw MMIO_BASE+8 -> 32'd5, since the counter increments on accept. Without the macro: same read -> rsp_err 1.
